// File: rtl/tl_demux.sv
// tl_demux: routes single- or multi-beat messages from one upstream
// valid/ready stream to one of N downstream ports.
//
// The first beat of a message is its header: sel_i picks the destination and
// len_i gives the beat count minus one. The route is latched for the rest of
// the burst. A message aimed at a port that does not exist (sel_i >= N) is
// swallowed whole and raises the sticky err_o flag.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i/ready_o   upstream handshake
//   data_i            upstream payload (DATA_W)
//   sel_i, len_i      destination / beats-minus-one, header beat only
//   valid_o[N]        per-port valid, one-hot or zero
//   ready_i[N]        per-port downstream ready
//   data_o[N*DATA_W]  per-port payload, lane k = [k*DATA_W +: DATA_W]
//   busy_o            burst in progress
//   err_o             sticky: a message was addressed to a missing port

// One output lane. Decodes whether the shared output register belongs to
// this port and, if so, presents it and reports a downstream pop.
module tl_demux_lane #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int IDX    = 0
) (
  input  logic              full_i,
  input  logic [SEL_W-1:0]  dest_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              pop_o
);
  logic hit;

  assign hit     = full_i && (dest_i == SEL_W'(IDX));
  assign valid_o = hit;
  assign data_o  = hit ? data_i : '0;
  assign pop_o   = hit && ready_i;
endmodule

module tl_demux #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic [N-1:0]        valid_o,
  input  logic [N-1:0]        ready_i,
  output logic [N*DATA_W-1:0] data_o,
  output logic                busy_o,
  output logic                err_o
);
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  // One extra bit so the comparison against N is exact even when N == 2**SEL_W.
  localparam logic [SEL_W:0] NPORTS = (SEL_W+1)'(N);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [SEL_W-1:0]   route_q, route_d;
  logic               drop_q, drop_d;   // current burst is unroutable

  logic               full_q, full_d;
  logic [SEL_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;

  logic [SEL_W-1:0]   cur_sel;
  logic               cur_bad;
  logic [N-1:0]       pop_vec;
  logic               pop;
  logic               acc;
  logic               wr;

  // ---------------------------------------------------------------------------
  // Output lanes
  // ---------------------------------------------------------------------------
  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_lane
      tl_demux_lane #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .IDX    (k)
      ) u_lane (
        .full_i  (full_q),
        .dest_i  (dest_q),
        .data_i  (data_q),
        .ready_i (ready_i[k]),
        .valid_o (valid_o[k]),
        .data_o  (data_o[k*DATA_W +: DATA_W]),
        .pop_o   (pop_vec[k])
      );
    end
  endgenerate

  // pop_vec can only be set on the lane that owns a full register, so its
  // OR is exactly full && ready_i[dest].
  assign pop = |pop_vec;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      route_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      route_q <= route_d;
      drop_q  <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    route_d = route_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          route_d = sel_i;
          drop_d  = cur_bad;
          if (len_i != '0) begin
            state_d = BURST;
            rem_d   = len_i;
          end
        end
      end
      BURST: begin
        if (acc) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and routing decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o  = (state_q == BURST);
    cur_sel = (state_q == IDLE) ? sel_i : route_q;
    cur_bad = (state_q == IDLE) ? ({1'b0, sel_i} >= NPORTS) : drop_q;
    // Unroutable beats are drained unconditionally so a stalled register
    // cannot block the error path.
    ready_o = rst_n && (cur_bad || !full_q || pop);
  end

  assign acc = valid_i && ready_o;
  assign wr  = acc && !cur_bad;

  // ---------------------------------------------------------------------------
  // Output register and sticky error
  // ---------------------------------------------------------------------------
  always_comb begin
    full_d = full_q;
    dest_d = dest_q;
    data_d = data_q;
    err_d  = err_q;
    if (wr) begin
      // Covers simultaneous pop + load: register reloads with no bubble.
      full_d = 1'b1;
      dest_d = cur_sel;
      data_d = data_i;
    end else if (pop) begin
      full_d = 1'b0;
    end
    if (acc && (state_q == IDLE) && cur_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_tl_demux.sv
module tb_tl_demux;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int LEN_W  = 4;

  logic                clk = 0;
  logic                rst_n;
  logic                valid_i;
  logic                ready_o;
  logic [DATA_W-1:0]   data_i;
  logic [SEL_W-1:0]    sel_i;
  logic [LEN_W-1:0]    len_i;
  logic [N-1:0]        valid_o;
  logic [N-1:0]        ready_i;
  logic [N*DATA_W-1:0] data_o;
  logic                busy_o;
  logic                err_o;

  tl_demux #(.N(N), .DATA_W(DATA_W), .SEL_W(SEL_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .sel_i(sel_i), .len_i(len_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic [DATA_W-1:0] d; } beat_t;
  beat_t sb[$];

  int compared   = 0;
  int mismatched = 0;
  bit exp_busy   = 0;
  bit exp_err    = 0;
  bit rdy_mode   = 0;   // 1: randomise ready_i every cycle

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Random downstream backpressure, biased towards ready.
  always @(posedge clk) begin
    #1;
    if (rdy_mode) ready_i = N'($urandom | $urandom);
  end

  // Monitor: every delivered beat is popped from the scoreboard.
  bit                  prev_stall = 0;
  logic [N-1:0]        prev_v;
  logic [N*DATA_W-1:0] prev_d;
  always @(negedge clk) begin
    int p;
    beat_t e;
    logic [N*DATA_W-1:0] ev;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      chk("busy", 64'(busy_o), 64'(exp_busy));
      chk("err", 64'(err_o), 64'(exp_err));
      if (valid_o != '0) begin
        p = 0;
        for (int k = 0; k < N; k++) if (valid_o[k]) p = k;
        chk("onehot", 64'($onehot(valid_o)), 64'(1));
        if (prev_stall) begin
          chk("stall_valid", 64'(valid_o), 64'(prev_v));
          chk("stall_data", 64'(data_o), 64'(prev_d));
        end
        if (ready_i[p]) begin
          if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_beat: got port %0d data %0h expected none", p, data_o);
          end else begin
            e  = sb.pop_front();
            ev = '0;
            ev[e.port*DATA_W +: DATA_W] = e.d;
            chk("port", 64'(p), 64'(e.port));
            chk("data", 64'(data_o), 64'(ev));
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_v = valid_o;
          prev_d = data_o;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  // Present one beat and hold it until the handshake completes.
  task automatic drive_beat(input logic [SEL_W-1:0] s, input logic [LEN_W-1:0] l,
                            input logic [DATA_W-1:0] d, output bit ok);
    int t = 0;
    valid_i = 1; sel_i = s; len_i = l; data_i = d; ok = 1;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      if (++t > 400) begin
        compared++; mismatched++;
        $display("FAIL accept_timeout: got no ready_o expected accept within 400 cycles");
        ok = 0; valid_i = 0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Message-level reference: a message of len+1 beats to port sel; every beat
  // lands on sel if sel < N, otherwise all beats vanish and err is raised.
  task automatic send_msg(input int sel, input int len, input bit gaps,
                          input int fixd, input int max_beats);
    bit bad = (sel >= N);
    for (int b = 0; b <= len && b < max_beats; b++) begin
      logic [DATA_W-1:0] d;
      logic [SEL_W-1:0]  s;
      logic [LEN_W-1:0]  l;
      bit ok;
      d = (fixd >= 0) ? DATA_W'(fixd + b) : DATA_W'($urandom);
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_i = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      // Non-header beats carry junk sel/len that must be ignored.
      s = (b == 0) ? SEL_W'(sel) : SEL_W'($urandom);
      l = (b == 0) ? LEN_W'(len) : LEN_W'($urandom);
      drive_beat(s, l, d, ok);
      if (!ok) return;
      if (!bad) sb.push_back('{sel, d});
      if (bad && b == 0) exp_err = 1;
      exp_busy = (b < len);
    end
    valid_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready_o"}, 64'(ready_o), 64'(0));
    chk({tag, "_valid_o"}, 64'(valid_o), 64'(0));
    chk({tag, "_data_o"},  64'(data_o),  64'(0));
    chk({tag, "_busy_o"},  64'(busy_o),  64'(0));
    chk({tag, "_err_o"},   64'(err_o),   64'(0));
  endtask

  initial begin
    int w;
    rst_n = 0; valid_i = 0; data_i = '0; sel_i = '0; len_i = '0; ready_i = '1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1;

    // Single beat A5 to port 2.
    send_msg(2, 0, 0, 8'hA5, 99);
    // Four-beat burst A0..A3 to port 1, then a header routed by a new sel.
    send_msg(1, 3, 0, 8'hA0, 99);
    send_msg(3, 0, 0, 8'h77, 99);

    // Backpressure on port 0 holding 5C; next beat waits, then goes with the pop.
    ready_i = 4'b1110;
    send_msg(0, 0, 0, 8'h5C, 99);
    fork
      send_msg(0, 0, 0, 8'h33, 99);
      begin
        repeat (3) begin @(negedge clk); chk("bp_ready_o", 64'(ready_o), 64'(0)); end
        @(posedge clk); #1 ready_i = '1;
      end
    join

    // Unroutable destination, then a normal message to port 0.
    send_msg(5, 1, 0, 8'h10, 99);
    send_msg(0, 0, 0, 8'h20, 99);

    // Maximum length burst: 16 beats.
    send_msg(2, 15, 0, 8'h40, 99);

    // Randomised traffic with gaps and backpressure.
    rdy_mode = 1;
    for (int m = 0; m < 40; m++)
      send_msg($urandom_range(0, 7), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3)
               : $urandom_range(0, 15), 1, -1, 99);
    rdy_mode = 0;
    @(posedge clk); #1 ready_i = '1;
    w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end

    // Reset after the 2nd of 4 beats.
    send_msg(1, 3, 0, 8'hB0, 2);
    rst_n = 0;
    sb.delete();
    exp_busy = 0;
    exp_err  = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1;
    send_msg(3, 0, 0, 8'hC3, 99);

    w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tl_demux.md
TL_DEMUX -- requirements
Module: tl_demux

Interface
REQ-001 Parameter N, default 4: number of downstream output ports.
REQ-002 Parameter DATA_W, default 8: payload width per beat.
REQ-003 Parameter SEL_W, default 2: destination-select width; SHALL be at least clog2(N).
REQ-004 Parameter LEN_W, default 4: burst-length field width.
REQ-005 Port clk  input  1  clock; all state changes on the rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port valid_i  input  1  upstream beat valid.
REQ-008 Port ready_o  output  1  upstream beat ready.
REQ-009 Port data_i  input  DATA_W  upstream payload.
REQ-010 Port sel_i  input  SEL_W  destination port index; sampled on the first beat of a message only.
REQ-011 Port len_i  input  LEN_W  beats minus one; sampled on the first beat only.
REQ-012 Port valid_o  output  N  per-port valid, one-hot or zero.
REQ-013 Port ready_i  input  N  per-port downstream ready.
REQ-014 Port data_o  output  N*DATA_W  per-port payload; lane k = bits [k*DATA_W +: DATA_W].
REQ-015 Port busy_o  output  1  high while a multi-beat burst is in progress (state BURST).
REQ-016 Port err_o  output  1  sticky flag: a message was addressed to sel_i >= N.

Function
REQ-017 A beat SHALL be accepted upstream exactly when valid_i && ready_o are both high at a rising edge.
REQ-018 A single output register SHALL hold {full, dest, data}; accepted routable beats are written into it, giving exactly 1 cycle of latency from acceptance to valid_o.
REQ-019 valid_o[k] SHALL equal full && (dest == k); data_o lane dest SHALL carry the register data, and all other lanes SHALL be zero.
REQ-020 ready_o SHALL equal !full || ready_i[dest], so that full throughput (1 beat per cycle) is sustained when the downstream port is ready.
REQ-021 A beat SHALL leave the register when full && ready_i[dest]; if there is no simultaneous accept, full SHALL clear. If there is a simultaneous accept, the register SHALL reload with no bubble.
REQ-022 valid_o and data_o SHALL stay stable while full && !ready_i[dest].
REQ-023 The FSM SHALL have states IDLE and BURST, plus a LEN_W-bit remaining counter and a latched route.
REQ-024 In IDLE, an accepted beat SHALL latch route = sel_i. If len_i == 0 the FSM stays in IDLE. Otherwise it goes to BURST with remaining = len_i.
REQ-025 In BURST, sel_i and len_i SHALL be ignored; every beat uses the latched route. remaining decrements per accepted beat, and the FSM returns to IDLE on the accepted beat where remaining == 1.
REQ-026 A message whose first-beat sel_i >= N SHALL be handled as follows: all of its beats are accepted (ready_o = 1 for them regardless of full) and dropped, never written to the register, and err_o is set on the first beat.
REQ-027 err_o SHALL stay set until reset.
REQ-028 The route SHALL not change mid-burst even if the register is stalled; a new route takes effect only on the first beat after returning to IDLE.
REQ-029 len_i at its maximum (all ones) SHALL produce 2^LEN_W beats with no counter wrap.
REQ-030 busy_o SHALL be high exactly while the FSM is in BURST.

Reset
REQ-031 While rst_n is low: full = 0, valid_o = 0, data_o = 0, busy_o = 0, err_o = 0, FSM in IDLE, remaining = 0; no beat is accepted.
REQ-032 Reset asserted mid-burst or with the register full SHALL discard the in-flight beat and the burst. The first accepted beat after release SHALL be treated as a message header.

Verification
REQ-033 Single beat: data_i = A5, sel_i = 2, len_i = 0, all ready_i = 1 -> next cycle valid_o = 0100, lane 2 = A5, other lanes 00; busy_o = 0.
REQ-034 Burst: sel_i = 1, len_i = 3, beats A0..A3 back-to-back; sel_i changed to 3 after the first beat -> valid_o = 0010 on 4 consecutive cycles carrying A0, A1, A2, A3; busy_o high for 3 cycles; the next header routes by the new sel_i.
REQ-035 Backpressure: ready_i[0] = 0 with the register full for port 0 holding 5C -> ready_o = 0, valid_o = 0001 and 5C held stable; raising ready_i[0] -> 5C delivered and the next beat accepted in the same cycle.
REQ-036 Bad destination: N = 4, SEL_W = 3, sel_i = 5, len_i = 1 -> 2 beats accepted, valid_o remains 0000, err_o = 1 and stays 1; the following sel_i = 0 message is delivered normally.
REQ-037 Reset mid-burst: rst_n pulsed low after the 2nd of 4 beats -> all outputs 0; after release, a beat with sel_i = 3, len_i = 0 appears on port 3 only.
